// File: rtl/trivium_ctrl.sv
// trivium_ctrl: clear/load/warm-up sequencer for three external Trivium shift
// registers (A 93b, B 84b, C 111b) and packer of their keystream into 32-bit words.
module trivium_ctrl #(
  parameter int unsigned WARMUP_CYCLES = 1152,
  parameter int unsigned WARM_CNT_W    = 11
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_we_i,
  input  logic [2:0]  cfg_addr_i,
  input  logic [31:0] cfg_dat_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        regs_n_rst_o,
  output logic [2:0]  ld_a_o,
  output logic [2:0]  ld_b_o,
  output logic [2:0]  ld_c_o,
  output logic [31:0] ld_dat_o,
  output logic        ce_o,
  input  logic        z_i,
  output logic [31:0] ks_dat_o,
  output logic        ks_vld_o,
  input  logic        ks_rdy_i
);

  // state | meaning
  // IDLE  | waiting for start, config writable
  // CLR   | shift registers held in reset for one cycle
  // LOAD  | key words into A, then IV words into B, one word per cycle
  // WARM  | registers clocked WARMUP_CYCLES times, keystream discarded
  // RUN   | keystream collected into 32-bit words, config writable
  typedef enum logic [2:0] {IDLE, CLR, LOAD, WARM, RUN} state_t;

  localparam logic [WARM_CNT_W-1:0] WARM_LAST = WARM_CNT_W'(WARMUP_CYCLES - 1);

  state_t                state_q, state_d;
  logic [31:0]           cfg_q [6];
  logic [2:0]            ld_idx_q;
  logic [WARM_CNT_W-1:0] warm_cnt_q;
  logic [31:0]           sr_q;
  logic [5:0]            bit_cnt_q;
  logic [31:0]           ks_dat_q;
  logic                  ks_vld_q;
  logic                  regs_n_rst_q;
  logic                  word_full;
  logic                  cfg_wr_en;
  logic                  ks_load;

  assign word_full = (bit_cnt_q == 6'd32);
  assign cfg_wr_en = cfg_we_i && !busy_o;
  assign ks_load   = (state_q == RUN) && word_full && (!ks_vld_q || ks_rdy_i);

  // Key word 2 and IV word 2 carry only 16 bits (80-bit key/IV).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 6; i++) cfg_q[i] <= '0;
    end else if (cfg_wr_en) begin
      for (int i = 0; i < 6; i++) begin
        if (cfg_addr_i == 3'(i))
          cfg_q[i] <= (i == 2 || i == 5) ? {16'h0000, cfg_dat_i[15:0]} : cfg_dat_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    busy_o   = 1'b0;
    ce_o     = 1'b0;
    ld_a_o   = 3'b000;
    ld_b_o   = 3'b000;
    ld_dat_o = '0;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = CLR;
      end
      CLR: begin
        busy_o  = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        busy_o   = 1'b1;
        ld_dat_o = cfg_q[ld_idx_q];
        if (ld_idx_q < 3'd3) ld_a_o = 3'b001 << ld_idx_q;
        else                 ld_b_o = 3'b001 << (ld_idx_q - 3'd3);
        if (ld_idx_q == 3'd5) state_d = WARM;
      end
      WARM: begin
        busy_o = 1'b1;
        ce_o   = 1'b1;
        if (warm_cnt_q == '0) state_d = RUN;
      end
      RUN: begin
        ce_o = !word_full;
        if (start_i) state_d = CLR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered so the register reset is free of decode glitches.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      regs_n_rst_q <= 1'b0;
      ld_idx_q     <= '0;
      warm_cnt_q   <= '0;
    end else begin
      regs_n_rst_q <= (state_d != CLR);
      ld_idx_q     <= (state_q == LOAD) ? ld_idx_q + 3'd1 : 3'd0;
      if (state_q == LOAD)
        warm_cnt_q <= WARM_LAST;
      else if (state_q == WARM && warm_cnt_q != '0)
        warm_cnt_q <= warm_cnt_q - WARM_CNT_W'(1);
    end
  end

  // Collector: a full word with the output slot occupied freezes ce_o, so no z bit is lost.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
      ks_dat_q  <= '0;
      ks_vld_q  <= 1'b0;
    end else if (state_d == CLR) begin
      bit_cnt_q <= '0;
      ks_vld_q  <= 1'b0;
    end else begin
      if (state_q == RUN && !word_full) begin
        sr_q[bit_cnt_q[4:0]] <= z_i;
        bit_cnt_q            <= bit_cnt_q + 6'd1;
      end
      if (ks_load) begin
        ks_dat_q  <= sr_q;
        ks_vld_q  <= 1'b1;
        bit_cnt_q <= '0;
      end else if (ks_vld_q && ks_rdy_i) begin
        ks_vld_q <= 1'b0;
      end
    end
  end

  assign regs_n_rst_o = regs_n_rst_q;
  assign ld_c_o       = 3'b000;
  assign ks_dat_o     = ks_dat_q;
  assign ks_vld_o     = ks_vld_q;

endmodule

// File: tb/tb_trivium_ctrl.sv
// tb_trivium_ctrl: drives the controller against a model of the three Trivium
// registers and checks keystream words against a direct Trivium reference.
module tb_trivium_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cfg_we_i = 1'b0;
  logic [2:0]  cfg_addr_i = 3'd0;
  logic [31:0] cfg_dat_i = 32'd0;
  logic        start_i = 1'b0;
  logic        ks_rdy_i = 1'b0;
  logic        busy_o, regs_n_rst_o, ce_o, z_i, ks_vld_o;
  logic [2:0]  ld_a_o, ld_b_o, ld_c_o;
  logic [31:0] ld_dat_o, ks_dat_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0]  key_m [3];
  logic [31:0]  iv_m [3];
  logic [31:0]  exp_q [$];
  logic [288:1] plant;

  trivium_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
    .cfg_dat_i(cfg_dat_i), .start_i(start_i), .busy_o(busy_o),
    .regs_n_rst_o(regs_n_rst_o), .ld_a_o(ld_a_o), .ld_b_o(ld_b_o), .ld_c_o(ld_c_o),
    .ld_dat_o(ld_dat_o), .ce_o(ce_o), .z_i(z_i), .ks_dat_o(ks_dat_o),
    .ks_vld_o(ks_vld_o), .ks_rdy_i(ks_rdy_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Trivium state s1..s288 held as plant[1]..plant[288]
  function automatic logic triv_z(input logic [288:1] s);
    return s[66] ^ s[93] ^ s[162] ^ s[177] ^ s[243] ^ s[288];
  endfunction

  function automatic logic [288:1] triv_step(input logic [288:1] s);
    logic t1, t2, t3;
    logic [288:1] n;
    t1 = s[66]  ^ s[93]  ^ (s[91] & s[92])   ^ s[171];
    t2 = s[162] ^ s[177] ^ (s[175] & s[176]) ^ s[264];
    t3 = s[243] ^ s[288] ^ (s[286] & s[287]) ^ s[69];
    n = s << 1;
    n[1]   = t3;
    n[94]  = t1;
    n[178] = t2;
    return n;
  endfunction

  always @(posedge clk_i) begin : plant_model
    logic [288:1] nx;
    nx = plant;
    if (!regs_n_rst_o) begin
      nx = {3'b111, 285'd0};
    end else begin
      if (ld_a_o[0]) nx[32:1]    = ld_dat_o;
      if (ld_a_o[1]) nx[64:33]   = ld_dat_o;
      if (ld_a_o[2]) nx[80:65]   = ld_dat_o[15:0];
      if (ld_b_o[0]) nx[125:94]  = ld_dat_o;
      if (ld_b_o[1]) nx[157:126] = ld_dat_o;
      if (ld_b_o[2]) nx[173:158] = ld_dat_o[15:0];
      if (ce_o) nx = triv_step(plant);
    end
    plant <= nx;
  end
  assign z_i = triv_z(plant);

  task automatic build_ref(input int nwords);
    logic [288:1] s;
    logic [31:0]  w;
    s = {3'b111, 285'd0};
    for (int k = 0; k < 80; k++) begin
      s[1 + k]  = key_m[k / 32][k % 32];
      s[94 + k] = iv_m[k / 32][k % 32];
    end
    for (int i = 0; i < 1152; i++) s = triv_step(s);
    exp_q.delete();
    for (int n = 0; n < nwords; n++) begin
      for (int b = 0; b < 32; b++) begin
        w[b] = triv_z(s);
        s = triv_step(s);
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    cfg_we_i = 1'b1;
    cfg_addr_i = a;
    cfg_dat_i = d;
    tick();
    cfg_we_i = 1'b0;
  endtask

  task automatic set_key(input logic [31:0] k0, k1, k2, i0, i1, i2);
    cfg_write(3'd0, k0);
    cfg_write(3'd1, k1);
    cfg_write(3'd2, k2);
    cfg_write(3'd3, i0);
    cfg_write(3'd4, i1);
    cfg_write(3'd5, i2);
    cfg_write(3'd6, $urandom);
    cfg_write(3'd7, $urandom);
    key_m[0] = k0; key_m[1] = k1; key_m[2] = {16'h0000, k2[15:0]};
    iv_m[0]  = i0; iv_m[1]  = i1; iv_m[2]  = {16'h0000, i2[15:0]};
  endtask

  task automatic set_key_rand();
    set_key($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_flags"}, {28'd0, busy_o, ce_o, ks_vld_o, regs_n_rst_o}, 32'd0);
    check({tag, "_ld_sel"}, {23'd0, ld_a_o, ld_b_o, ld_c_o}, 32'd0);
    check({tag, "_ld_dat"}, ld_dat_o, 32'd0);
    check({tag, "_ks_dat"}, ks_dat_o, 32'd0);
  endtask

  // mode 1: junk config writes early in WARM; mode 2: start pulse in WARM
  task automatic run_to_run(input int mode);
    int ce_cnt;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("clr_flags", {28'd0, busy_o, ce_o, ks_vld_o, regs_n_rst_o}, 32'h8);
    tick();
    for (int i = 0; i < 6; i++) begin
      logic [2:0]  ea, eb;
      logic [31:0] ed, md;
      if (i < 3) begin
        ea = 3'(1 << i); eb = 3'd0; ed = key_m[i];
      end else begin
        ea = 3'd0; eb = 3'(1 << (i - 3)); ed = iv_m[i - 3];
      end
      md = (i == 2 || i == 5) ? 32'h0000_ffff : 32'hffff_ffff;
      check("ld_sel", {26'd0, ld_a_o, ld_b_o}, {26'd0, ea, eb});
      check("ld_dat", ld_dat_o & md, ed & md);
      check("ld_ctrl", {26'd0, ld_c_o, ce_o, busy_o, regs_n_rst_o}, 32'h3);
      tick();
    end
    ce_cnt = 0;
    for (int i = 0; i < 1152; i++) begin
      cfg_we_i   = (mode == 1 && i < 6);
      cfg_addr_i = 3'(i);
      cfg_dat_i  = $urandom;
      start_i    = (mode == 2 && i == 92);
      if (ce_o && busy_o) ce_cnt++;
      tick();
    end
    cfg_we_i = 1'b0;
    start_i  = 1'b0;
    check("warm_cycles", ce_cnt, 1152);
    check("run_entry", {30'd0, busy_o, ce_o}, 32'd1);
  endtask

  task automatic wait_vld(input string tag, input int limit, output int k);
    k = 0;
    while (!ks_vld_o && k < limit) begin
      tick();
      k++;
    end
    check({tag, "_vld"}, 32'(ks_vld_o), 32'd1);
  endtask

  task automatic collect(input int nwords, input int rdy_pct, input string tag, output int gap);
    int got, cyc, last;
    logic pend;
    logic [31:0] pend_dat;
    got = 0; cyc = 0; last = -1; gap = 0;
    pend = 1'b0; pend_dat = 32'd0;
    while (got < nwords && cyc < 1400 + nwords * 200) begin
      ks_rdy_i = ($urandom_range(0, 99) < rdy_pct);
      if (pend) begin
        check({tag, "_hold_vld"}, 32'(ks_vld_o), 32'd1);
        check({tag, "_hold_dat"}, ks_dat_o, pend_dat);
      end
      if (ks_vld_o && ks_rdy_i) begin
        check(tag, ks_dat_o, exp_q.pop_front());
        if (last >= 0) gap = cyc - last;
        last = cyc;
        got++;
      end
      pend = ks_vld_o && !ks_rdy_i;
      pend_dat = ks_dat_o;
      tick();
      cyc++;
    end
    check({tag, "_count"}, got, nwords);
  endtask

  initial begin
    int gap, k, bad, ce_cnt;
    logic [31:0] d;

    // reset and idle
    tick();
    tick();
    check_reset("rst_hold");
    rst_i = 1'b0;
    check("rst_release_low", 32'(regs_n_rst_o), 32'd0);
    tick();
    check("rst_release_high", 32'(regs_n_rst_o), 32'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (ce_o || busy_o || ks_vld_o) bad++;
      tick();
    end
    check("idle_quiet", bad, 0);

    // all-zero key/IV, cadence with consumer always ready
    set_key(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    build_ref(12);
    ks_rdy_i = 1'b1;
    run_to_run(0);
    wait_vld("first", 100, k);
    check("first_vld_lat", k, 33);
    collect(4, 100, "ks_zero", gap);
    check("cadence", gap, 33);

    // backpressure
    ks_rdy_i = 1'b0;
    wait_vld("bp", 100, k);
    d = ks_dat_o;
    bad = 0;
    ce_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (ks_vld_o !== 1'b1 || ks_dat_o !== d) bad++;
      if (ce_o) ce_cnt++;
      tick();
    end
    check("bp_hold_bad", bad, 0);
    check("bp_ce_cycles", ce_cnt, 32);
    check("bp_ce_frozen", 32'(ce_o), 32'd0);
    collect(4, 60, "ks_bp", gap);

    // config writes while busy are dropped; restart with a pending word
    set_key_rand();
    build_ref(6);
    run_to_run(1);
    collect(3, 70, "ks_k1", gap);
    ks_rdy_i = 1'b0;
    wait_vld("pend", 100, k);
    build_ref(6);
    run_to_run(0);
    collect(3, 70, "ks_k1_again", gap);

    // start ignored while busy; restart at RUN cycle 10
    set_key_rand();
    build_ref(4);
    run_to_run(2);
    repeat (10) tick();
    run_to_run(0);
    collect(3, 80, "ks_k3", gap);

    // asynchronous reset at WARM cycle 500
    set_key_rand();
    ks_rdy_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (507) tick();
    check("warm500", {30'd0, busy_o, ce_o}, 32'd3);
    rst_i = 1'b1;
    #1;
    check_reset("async_rst");
    tick();
    rst_i = 1'b0;
    check("rst2_release_low", 32'(regs_n_rst_o), 32'd0);
    tick();
    check("rst2_release_high", 32'(regs_n_rst_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      key_m[i] = 32'd0;
      iv_m[i]  = 32'd0;
    end
    build_ref(2);
    run_to_run(0);
    collect(2, 100, "ks_cfg_cleared", gap);
    set_key_rand();
    build_ref(3);
    run_to_run(0);
    collect(3, 50, "ks_post_rst", gap);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
